// File: rtl/testing_pio_pkg.sv
// Shared definitions for the testing PIO input and output ports:
// register word addresses and the edge-select encodings.
package testing_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/testing_keys_debounce.sv
// Per-bit counter debounce filter: a bit's output follows its input only after
// the input has disagreed with the output for DEBOUNCE_CYCLES consecutive cycles.
module testing_keys_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] level
);

    localparam logic [15:0] THRESH = 16'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [15:0] cnt;
        logic        lvl;

        // cnt counts consecutive disagreeing cycles; agreement restarts it
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == THRESH) begin
                lvl <= sync[i];
                cnt <= '0;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign level[i] = lvl;
    end

endmodule

// File: rtl/testing_keys_in.sv
// Avalon-MM input PIO: synchronized (optionally debounced) inputs, edge capture
// with W1C clear and a maskable level irq. Option macro: TESTING_KEYS_IN_DEBOUNCE_EN.
module testing_keys_in
    import testing_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("testing_keys_in: WIDTH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
        $error("testing_keys_in: DEBOUNCE_CYCLES must be 2..65535");
    end
    if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
        $error("testing_keys_in: EDGE_TYPE must be 0..2");
    end

`ifdef TESTING_KEYS_IN_DEBOUNCE_EN
    localparam int WARM_CYCLES = DEBOUNCE_CYCLES + 3;
`else
    localparam int WARM_CYCLES = 3;
`endif
    localparam int WARM_W = $clog2(WARM_CYCLES + 1);

    logic [WIDTH-1:0]  sync_p0;
    logic [WIDTH-1:0]  sync_p1;
    logic [WIDTH-1:0]  level;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_cap;
    logic [WIDTH-1:0]  edge_hit;
    logic [WIDTH-1:0]  cap_clr;
    logic [WARM_W-1:0] warm_cnt;
    logic              warm_done;
    logic              wr_en;
    logic [31:0]       rd_next;
    logic              unused_wdata;

    function automatic logic [WIDTH-1:0] edge_select(input logic [WIDTH-1:0] lvl,
                                                     input logic [WIDTH-1:0] prv);
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        rise = lvl & ~prv;
        fall = ~lvl & prv;
        if (EDGE_TYPE == EDGE_RISE)      return rise;
        else if (EDGE_TYPE == EDGE_FALL) return fall;
        else                             return rise | fall;
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= in_port;
            sync_p1 <= sync_p0;
        end
    end

`ifdef TESTING_KEYS_IN_DEBOUNCE_EN
    testing_keys_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .sync   (sync_p1),
        .level  (level)
    );
`else
    assign level = sync_p1;
`endif

    assign warm_done = (warm_cnt == WARM_W'(WARM_CYCLES));
    assign wr_en     = chipselect & ~write_n;
    assign edge_hit  = warm_done ? edge_select(level, prev) : '0;
    assign cap_clr   = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

    // Warm-up hides the edge produced when prev/sync leave their reset value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
            prev     <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (!warm_done) warm_cnt <= warm_cnt + WARM_W'(1);
            prev     <= level;
            // a fresh edge wins over a same-cycle clear
            edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
            if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:     rd_next[WIDTH-1:0] = level;
            ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_next[WIDTH-1:0] = edge_cap;
            default:       rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    assign irq          = |(edge_cap & irq_mask);
    assign unused_wdata = ^writedata;

endmodule
